sentinel_entropy_arbiter: RTL
=============================

Name: sentinel_entropy_arbiter

Overview:
Sequences the ring-oscillator entropy harvester and shares its seeds between NUM_REQ consumers (QRNG DRBG reseed, key-gen, nonce engine, ...).
- Re-arms the harvester, captures each 256-bit word and runs a monobit health test on it.
- Buffers one passing seed and hands it out by round-robin with a req/gnt handshake.
- Escalates repeated health failures to a sticky fault that blocks all delivery.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
SEED_WIDTH, 256, seed width; matches harvester
ONES_LO, 96, minimum passing popcount (inclusive)
ONES_HI, 160, maximum passing popcount (inclusive)
MAX_FAIL, 3, consecutive health failures that set fault
TIMEOUT, 1024, max cycles in COLLECT before counting a failure

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
harv_rst_n  out  1  active-low restart to harvester
harv_entropy  in  SEED_WIDTH  harvester word
harv_ready  in  1  harvester word valid
req  in  NUM_REQ  seed request; held high until granted
gnt  out  NUM_REQ  one-hot, single-cycle grant
seed_out  out  SEED_WIDTH  seed; valid only in gnt cycle, else '0
fault  out  1  sticky health fault
clear_fault  in  1  pulse; clears fault, restarts harvesting
fail_cnt  out  $clog2(MAX_FAIL+1)  consecutive failure count

Behaviour:
- Reset values:
  - harv_rst_n=0; gnt='0; seed_out='0; fault=0; fail_cnt=0.
  - Buffer empty; RR pointer=0; state=RESTART.
- FSM states: RESTART, COLLECT, TEST, FULL, FAULT.
- RESTART:
  - Drives harv_rst_n=0 for exactly 2 cycles, then -> COLLECT.
  - harv_rst_n is registered.
- COLLECT:
  - harv_rst_n=1; cycle counter counts from 0.
  - First cycle with harv_ready=1: latch harv_entropy into cand_reg, -> TEST.
  - If the counter reaches TIMEOUT-1 with no harv_ready: count as a failure, handled as in TEST.
- TEST (1 cycle):
  - Pass: popcount(cand_reg) within [ONES_LO, ONES_HI]. Copy cand_reg to buffer, fail_cnt=0, -> FULL.
  - Fail: fail_cnt+1.
    - If the new fail_cnt equals MAX_FAIL: set fault=1, -> FAULT.
    - Otherwise -> RESTART.
  - cand_reg is cleared to '0 after TEST in both cases.
- FULL:
  - If req != 0: pick the first set bit at or after the RR pointer, wrapping modulo NUM_REQ.
  - Next cycle: that gnt bit=1 and seed_out=buffer.
  - Same edge: buffer zeroised, RR pointer = granted index+1 (wraps), -> RESTART.
  - Exactly one grant per harvested seed; a seed is never delivered twice.
  - Latency: req seen in FULL -> gnt on the following cycle.
- req timing:
  - req asserted while the FSM is not in FULL waits.
  - Requesters may drop req before grant; a dropped request is simply not granted.
  - Simultaneous reqs are served by RR order.
- FAULT:
  - gnt held '0; buffer zeroised; harv_rst_n=0.
  - clear_fault=1: fault=0, fail_cnt=0, -> RESTART.
  - clear_fault outside FAULT is ignored.
- rst_n asserted mid-operation: everything returns to reset values immediately; buffer and cand_reg contents are lost (zeroised).

Decomposition:
- Package sentinel_pkg:
  - State enum arb_state_e {RESTART, COLLECT, TEST, FULL, FAULT}.
  - Defaults SEED_WIDTH_DEF=256, ONES_LO_DEF, ONES_HI_DEF.
- One sub-module: sentinel_rr_picker.
  - Combinational, parameter N.
  - Inputs: req, ptr.
  - Outputs: onehot grant, index, any.
  - Reused by the future key-slot scheduler.

Test Plan:
1. Reset, model harvester gives ready at cycle 257 with word of popcount 128, req=4'b0001 -> harv_rst_n low 2 cycles; gnt=0001 with that word one cycle after FULL; harv_rst_n pulses again.
2. req=4'b1111 held across 5 seeds -> grant order 0001,0010,0100,1000,0001; each seed distinct, no double grant.
3. Words with popcount 95, 161, then 128 -> fail_cnt 1, 2, then 0; third word delivered; ONES_LO/HI boundaries 96 and 160 pass.
4. Three words of all-ones -> fault=1 after third TEST; no gnt despite req; clear_fault -> fault=0, RESTART, next good word granted.
5. harv_ready held 0 for TIMEOUT cycles -> fail_cnt=1, RESTART re-entered.
6. rst_n pulsed while in FULL with req pending -> no gnt; seed_out='0; state RESTART; buffer zero.

Source files
------------

// File: rtl/sentinel_pkg.sv
// Shared types and default parameters for the entropy arbiter and its helpers.
package sentinel_pkg;

    typedef enum logic [2:0] {
        RESTART = 3'd0,
        COLLECT = 3'd1,
        TEST    = 3'd2,
        FULL    = 3'd3,
        FAULT   = 3'd4
    } arb_state_e;

    localparam int SEED_WIDTH_DEF = 256;
    localparam int ONES_LO_DEF    = 96;
    localparam int ONES_HI_DEF    = 160;

endpackage

// File: rtl/sentinel_rr_picker.sv
// Combinational round-robin picker: first set request at or after ptr,
// wrapping modulo N. Reusable by other schedulers.
module sentinel_rr_picker #(
    parameter int N = 4,
    parameter int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] gnt,
    output logic [W-1:0] idx,
    output logic         any
);

    logic [W:0]   sum_s;
    logic [W-1:0] pos_s;

    // Scan requesters starting at ptr and keep the first one found.
    always_comb begin
        gnt   = '0;
        idx   = '0;
        any   = 1'b0;
        sum_s = '0;
        pos_s = '0;
        for (int i = 0; i < N; i++) begin
            sum_s = {1'b0, ptr} + (W+1)'(i);
            if (sum_s >= (W+1)'(N)) begin
                pos_s = W'(sum_s - (W+1)'(N));
            end else begin
                pos_s = sum_s[W-1:0];
            end
            if (!any && req[pos_s]) begin
                any      = 1'b1;
                gnt[pos_s] = 1'b1;
                idx      = pos_s;
            end else begin
                any = any;
            end
        end
    end

endmodule

// File: rtl/sentinel_entropy_arbiter.sv
// Sequences the ring-oscillator harvester, health-tests each word with a
// monobit popcount window, buffers one good seed and hands it out once by
// round-robin. Repeated health failures latch a sticky fault.
module sentinel_entropy_arbiter
    import sentinel_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int SEED_WIDTH = SEED_WIDTH_DEF,
    parameter int ONES_LO    = ONES_LO_DEF,
    parameter int ONES_HI    = ONES_HI_DEF,
    parameter int MAX_FAIL   = 3,
    parameter int TIMEOUT    = 1024
) (
    input  logic                          clk,
    input  logic                          rst_n,
    output logic                          harv_rst_n,
    input  logic [SEED_WIDTH-1:0]         harv_entropy,
    input  logic                          harv_ready,
    input  logic [NUM_REQ-1:0]            req,
    output logic [NUM_REQ-1:0]            gnt,
    output logic [SEED_WIDTH-1:0]         seed_out,
    output logic                          fault,
    input  logic                          clear_fault,
    output logic [$clog2(MAX_FAIL+1)-1:0] fail_cnt
);

    localparam int PW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int FW  = $clog2(MAX_FAIL + 1);
    localparam int TW  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int PCW = $clog2(SEED_WIDTH + 1);

    // Number of ones in a harvested word.
    function automatic logic [PCW-1:0] popcount(input logic [SEED_WIDTH-1:0] w);
        logic [PCW-1:0] c;
        c = '0;
        for (int i = 0; i < SEED_WIDTH; i++) begin
            c = c + {{(PCW-1){1'b0}}, w[i]};
        end
        return c;
    endfunction

    arb_state_e              state_r;
    logic                    restart_cnt_r;
    logic [TW-1:0]           timer_r;
    logic [SEED_WIDTH-1:0]   cand_r;
    logic [SEED_WIDTH-1:0]   buf_r;
    logic [PW-1:0]           ptr_r;
    logic [FW-1:0]           fail_cnt_r;
    logic                    fault_r;
    logic [NUM_REQ-1:0]      gnt_r;
    logic [SEED_WIDTH-1:0]   seed_r;
    logic                    harv_rst_n_r;

    logic [NUM_REQ-1:0]      pick_gnt_s;
    logic [PW-1:0]           pick_idx_s;
    logic                    pick_any_s;
    logic [PW-1:0]           ptr_next_s;
    logic [PCW-1:0]          ones_s;
    logic                    pass_s;
    logic [FW-1:0]           fail_inc_s;
    logic                    fail_max_s;

    sentinel_rr_picker #(.N(NUM_REQ), .W(PW)) u_picker (
        .req (req),
        .ptr (ptr_r),
        .gnt (pick_gnt_s),
        .idx (pick_idx_s),
        .any (pick_any_s)
    );

    // Health verdict, failure escalation and next RR pointer.
    always_comb begin
        ones_s     = popcount(cand_r);
        pass_s     = (ones_s >= PCW'(ONES_LO)) && (ones_s <= PCW'(ONES_HI));
        fail_inc_s = fail_cnt_r + FW'(1);
        fail_max_s = (fail_inc_s == FW'(MAX_FAIL));
        if (pick_idx_s == PW'(NUM_REQ - 1)) begin
            ptr_next_s = '0;
        end else begin
            ptr_next_s = pick_idx_s + PW'(1);
        end
    end

    // Sequencer FSM with all outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= RESTART;
            restart_cnt_r <= 1'b0;
            timer_r       <= '0;
            cand_r        <= '0;
            buf_r         <= '0;
            ptr_r         <= '0;
            fail_cnt_r    <= '0;
            fault_r       <= 1'b0;
            gnt_r         <= '0;
            seed_r        <= '0;
            harv_rst_n_r  <= 1'b0;
        end else begin
            gnt_r  <= '0;
            seed_r <= '0;
            case (state_r)
                RESTART: begin
                    harv_rst_n_r <= 1'b0;
                    if (restart_cnt_r) begin
                        restart_cnt_r <= 1'b0;
                        timer_r       <= '0;
                        harv_rst_n_r  <= 1'b1;
                        state_r       <= COLLECT;
                    end else begin
                        restart_cnt_r <= 1'b1;
                    end
                end
                COLLECT: begin
                    if (harv_ready) begin
                        cand_r  <= harv_entropy;
                        state_r <= TEST;
                    end else if (timer_r == TW'(TIMEOUT - 1)) begin
                        // A silent harvester is treated like a failed word.
                        fail_cnt_r    <= fail_inc_s;
                        harv_rst_n_r  <= 1'b0;
                        restart_cnt_r <= 1'b0;
                        if (fail_max_s) begin
                            fault_r <= 1'b1;
                            state_r <= FAULT;
                        end else begin
                            state_r <= RESTART;
                        end
                    end else begin
                        timer_r <= timer_r + TW'(1);
                    end
                end
                TEST: begin
                    cand_r <= '0;
                    if (pass_s) begin
                        buf_r      <= cand_r;
                        fail_cnt_r <= '0;
                        state_r    <= FULL;
                    end else begin
                        fail_cnt_r    <= fail_inc_s;
                        harv_rst_n_r  <= 1'b0;
                        restart_cnt_r <= 1'b0;
                        if (fail_max_s) begin
                            fault_r <= 1'b1;
                            state_r <= FAULT;
                        end else begin
                            state_r <= RESTART;
                        end
                    end
                end
                FULL: begin
                    if (pick_any_s) begin
                        // Deliver once, then forget the seed.
                        gnt_r         <= pick_gnt_s;
                        seed_r        <= buf_r;
                        buf_r         <= '0;
                        ptr_r         <= ptr_next_s;
                        harv_rst_n_r  <= 1'b0;
                        restart_cnt_r <= 1'b0;
                        state_r       <= RESTART;
                    end else begin
                        state_r <= FULL;
                    end
                end
                FAULT: begin
                    buf_r        <= '0;
                    harv_rst_n_r <= 1'b0;
                    if (clear_fault) begin
                        fault_r       <= 1'b0;
                        fail_cnt_r    <= '0;
                        restart_cnt_r <= 1'b0;
                        state_r       <= RESTART;
                    end else begin
                        fault_r <= 1'b1;
                    end
                end
                default: begin
                    harv_rst_n_r  <= 1'b0;
                    restart_cnt_r <= 1'b0;
                    state_r       <= RESTART;
                end
            endcase
        end
    end

    assign harv_rst_n = harv_rst_n_r;
    assign gnt        = gnt_r;
    assign seed_out   = seed_r;
    assign fault      = fault_r;
    assign fail_cnt   = fail_cnt_r;

endmodule
